chip8_sprite_draw: RTL and testbench

//  Sequencer for CHIP-8 DXYN: fetches N sprite bytes from memory and read-modify-writes

---
 rtl/chip8_sprite_draw.sv | 146 ++++++++++++++
 tb/tb_chip8_sprite_draw.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN sprite sequencer: fetches sprite bytes and XORs each one into a
// 64-bit framebuffer row with a read-modify-write, reporting pixel collisions.
module chip8_sprite_draw #(
    parameter bit CLIP_EN = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [7:0]  x_in,
    input  logic [7:0]  y_in,
    input  logic [3:0]  n_in,
    input  logic [11:0] sprite_addr_in,
    output logic        mem_req_out,
    output logic [11:0] mem_addr_out,
    input  logic        mem_valid_in,
    input  logic [7:0]  mem_data_in,
    output logic        fb_rd_en_out,
    output logic [4:0]  fb_row_out,
    input  logic [63:0] fb_rd_data_in,
    output logic        fb_wr_en_out,
    output logic [63:0] fb_wr_data_out,
    output logic        busy_out,
    output logic        done_out,
    output logic        collision_out
);
    // state | meaning
    // IDLE  | waiting for start_in
    // FETCH | requesting sprite byte at addr + r
    // FBRD  | reading the target framebuffer row
    // FBWR  | XOR-ing the sprite mask into the returned row
    // DONE  | one-cycle completion pulse, collision final
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        FBRD  = 3'd2,
        FBWR  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  x;
    logic [4:0]  y;
    logic [3:0]  n;
    logic [3:0]  r;
    logic [11:0] addr;
    logic [7:0]  sprite_byte;
    logic        collision;
    logic [4:0]  row;
    logic        wr_en;
    logic [63:0] wr_data;
    logic [5:0]  row_sum;
    logic        row_clipped;
    logic        last_row;
    logic [63:0] mask;
    logic [6:0]  col;
    logic        unused_bits;

    assign unused_bits = ^{x_in[7:6], y_in[7:5]};

    // Bit 5 of y + r set means the row fell off the bottom edge.
    assign row_sum     = {1'b0, y} + {2'b00, r};
    assign row_clipped = CLIP_EN && row_sum[5];
    assign last_row    = (r == n - 4'd1);

    always_comb begin
        mask = '0;
        col  = '0;
        for (int k = 0; k < 8; k++) begin
            col = {1'b0, x} + 7'(k);
            if (sprite_byte[3'(7 - k)] && !(CLIP_EN && col[6]))
                mask[col[5:0]] = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_in) state_nxt = (n_in == 4'd0) ? DONE : FETCH;
            FETCH: begin
                if (row_clipped)
                    state_nxt = DONE;
                else if (mem_valid_in)
                    state_nxt = FBRD;
            end
            FBRD:    state_nxt = FBWR;
            FBWR:    state_nxt = last_row ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            x           <= '0;
            y           <= '0;
            n           <= '0;
            r           <= '0;
            addr        <= '0;
            sprite_byte <= '0;
            collision   <= 1'b0;
            row         <= '0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
        end else begin
            wr_en <= 1'b0;
            if (state == IDLE && start_in) begin
                x         <= x_in[5:0];
                y         <= y_in[4:0];
                n         <= n_in;
                addr      <= sprite_addr_in;
                r         <= '0;
                collision <= 1'b0;
            end
            if (state == FETCH && !row_clipped && mem_valid_in) begin
                sprite_byte <= mem_data_in;
                row         <= row_sum[4:0];
            end
            // The write lands one cycle after FBWR; row stays put until the next FBRD.
            if (state == FBWR) begin
                wr_en     <= 1'b1;
                wr_data   <= fb_rd_data_in ^ mask;
                collision <= collision | (|(fb_rd_data_in & mask));
                if (!last_row)
                    r <= r + 4'd1;
            end
        end
    end

    assign mem_req_out    = (state == FETCH) && !row_clipped;
    assign mem_addr_out   = addr + {8'd0, r};
    assign fb_rd_en_out   = (state == FBRD);
    assign fb_row_out     = row;
    assign fb_wr_en_out   = wr_en;
    assign fb_wr_data_out = wr_data;
    assign busy_out       = (state != IDLE);
    assign done_out       = (state == DONE);
    assign collision_out  = collision;
endmodule

// File: tb/tb_chip8_sprite_draw.sv
// Bench for chip8_sprite_draw: a clipping and a wrapping instance run the same
// draws against memory/framebuffer models and a pixel-level reference.
module tb_chip8_sprite_draw;
    logic        clk_in;
    logic        rst_n;
    logic        start_in;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic [3:0]  n_in;
    logic [11:0] sprite_addr;

    logic        mem_req    [2];
    logic [11:0] mem_addr   [2];
    logic        mem_valid  [2];
    logic [7:0]  mem_data   [2];
    logic        fb_rd_en   [2];
    logic [4:0]  fb_row     [2];
    logic [63:0] fb_rd_data [2];
    logic        fb_wr_en   [2];
    logic [63:0] fb_wr_data [2];
    logic        busy       [2];
    logic        done       [2];
    logic        coll       [2];

    logic [7:0]  mem    [4096];
    logic [63:0] fb     [2][32];
    logic [63:0] exp_fb [2][32];
    logic [11:0] addr_log [2][256];
    int          req_cnt [2];
    int          req_cycles [2];
    int          rd_cnt [2];
    int          wr_cnt [2];
    int          overlap [2];
    int          wcnt [2];
    int          mem_lat;
    bit          fb_ready;
    int          checks;
    int          failures;

    // Instance 0 clips at the edges, instance 1 wraps.
    for (genvar g = 0; g < 2; g++) begin : gen_dut
        chip8_sprite_draw #(.CLIP_EN(g == 0)) dut (
            .clk_in         (clk_in),
            .rst_in         (rst_n),
            .start_in       (start_in),
            .x_in           (x_in),
            .y_in           (y_in),
            .n_in           (n_in),
            .sprite_addr_in (sprite_addr),
            .mem_req_out    (mem_req[g]),
            .mem_addr_out   (mem_addr[g]),
            .mem_valid_in   (mem_valid[g]),
            .mem_data_in    (mem_data[g]),
            .fb_rd_en_out   (fb_rd_en[g]),
            .fb_row_out     (fb_row[g]),
            .fb_rd_data_in  (fb_rd_data[g]),
            .fb_wr_en_out   (fb_wr_en[g]),
            .fb_wr_data_out (fb_wr_data[g]),
            .busy_out       (busy[g]),
            .done_out       (done[g]),
            .collision_out  (coll[g])
        );
    end

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Memory answers mem_lat cycles after the request first appears; framebuffer
    // read data is presented from the read cycle onward.
    always @(negedge clk_in) begin
        if (!fb_ready) begin
            for (int r = 0; r < 32; r++) begin
                fb[0][r] = '0;
                fb[1][r] = '0;
            end
            fb_ready = 1'b1;
        end
        for (int i = 0; i < 2; i++) begin
            if (mem_req[i] === 1'b1) req_cycles[i]++;
            if (!rst_n) begin
                mem_valid[i]  = 1'b0;
                mem_data[i]   = '0;
                fb_rd_data[i] = '0;
                wcnt[i]       = 0;
            end else if (mem_valid[i]) begin
                mem_valid[i] = 1'b0;
            end else if (mem_req[i] === 1'b1) begin
                if (wcnt[i] == mem_lat) begin
                    mem_valid[i] = 1'b1;
                    mem_data[i]  = mem[mem_addr[i]];
                    addr_log[i][req_cnt[i] & 255] = mem_addr[i];
                    req_cnt[i]++;
                    wcnt[i] = 0;
                end else begin
                    wcnt[i]++;
                end
            end else begin
                wcnt[i] = 0;
            end
            if (fb_rd_en[i] === 1'b1) begin
                fb_rd_data[i] = fb[i][fb_row[i]];
                rd_cnt[i]++;
            end
            if (fb_wr_en[i] === 1'b1) begin
                fb[i][fb_row[i]] = fb_wr_data[i];
                wr_cnt[i]++;
            end
            if (fb_rd_en[i] === 1'b1 && fb_wr_en[i] === 1'b1) overlap[i]++;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel-level DXYN reference applied to exp_fb.
    function automatic void ref_draw(input int inst, input int x, input int y, input int n,
                                     input int addr, input int max_rows,
                                     output bit c, output int drawn);
        bit clip;
        int row;
        int col;
        logic [7:0] b;
        clip  = (inst == 0);
        c     = 1'b0;
        drawn = 0;
        for (int r = 0; r < n && r < max_rows; r++) begin
            row = (y % 32) + r;
            if (clip && row > 31) break;
            row = row % 32;
            b = mem[(addr + r) % 4096];
            for (int k = 0; k < 8; k++) begin
                col = (x % 64) + k;
                if (b[7 - k] && !(clip && col > 63)) begin
                    col = col % 64;
                    if (exp_fb[inst][row][col]) c = 1'b1;
                    exp_fb[inst][row][col] = ~exp_fb[inst][row][col];
                end
            end
            drawn++;
        end
    endfunction

    task automatic check_fb(input string tag);
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 32; r++)
                check($sformatf("%s.u%0d.row%0d", tag, i, r), fb[i][r], exp_fb[i][r]);
    endtask

    task automatic check_outputs_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s.u%0d.ctrl", tag, i),
                  {41'd0, mem_req[i], mem_addr[i], fb_rd_en[i], fb_row[i], fb_wr_en[i],
                   busy[i], done[i], coll[i]}, 64'd0);
            check($sformatf("%s.u%0d.wr_data", tag, i), fb_wr_data[i], 64'd0);
        end
    endtask

    // p1/p2: cycles (counted from the accepted start) on which a stray start is pulsed.
    task automatic run_draw(input string tag, input int x, input int y, input int n,
                            input int addr, input int lat, input int p1, input int p2);
        bit ecoll [2];
        int edrawn [2];
        int dcyc [2];
        int gap [2];
        int s_req [2];
        int s_rc [2];
        int s_rd [2];
        int s_wr [2];
        int s_ov [2];
        int edone;
        mem_lat = lat;
        for (int i = 0; i < 2; i++) begin
            ref_draw(i, x, y, n, addr, 16, ecoll[i], edrawn[i]);
            s_req[i] = req_cnt[i];
            s_rc[i]  = req_cycles[i];
            s_rd[i]  = rd_cnt[i];
            s_wr[i]  = wr_cnt[i];
            s_ov[i]  = overlap[i];
            dcyc[i]  = -1;
            gap[i]   = 0;
        end
        @(negedge clk_in);
        x_in        = x[7:0];
        y_in        = y[7:0];
        n_in        = n[3:0];
        sprite_addr = addr[11:0];
        start_in    = 1'b1;
        for (int cyc = 1; cyc <= 600; cyc++) begin
            @(negedge clk_in);
            if (cyc == 1)
                for (int i = 0; i < 2; i++)
                    check($sformatf("%s.u%0d.coll_cleared", tag, i), coll[i], 1'b0);
            for (int i = 0; i < 2; i++) begin
                if (dcyc[i] < 0) begin
                    if (busy[i] !== 1'b1) gap[i]++;
                    if (done[i] === 1'b1) dcyc[i] = cyc;
                end
            end
            start_in = (cyc == p1 || cyc == p2);
            if (start_in) begin
                x_in        = 8'h3c;
                y_in        = 8'h11;
                n_in        = 4'hf;
                sprite_addr = 12'h000;
            end
            if (dcyc[0] >= 0 && dcyc[1] >= 0) break;
        end
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (2) @(negedge clk_in);
        for (int i = 0; i < 2; i++) begin
            edone = 1 + edrawn[i] * (lat + 3) + ((i == 0 && edrawn[i] < n) ? 1 : 0);
            check($sformatf("%s.u%0d.done_cycle", tag, i), 64'(dcyc[i]), 64'(edone));
            check($sformatf("%s.u%0d.collision", tag, i), coll[i], ecoll[i]);
            check($sformatf("%s.u%0d.busy_gaps", tag, i), 64'(gap[i]), 64'd0);
            check($sformatf("%s.u%0d.idle_after", tag, i), {busy[i], done[i]}, 2'b00);
            check($sformatf("%s.u%0d.mem_reqs", tag, i), 64'(req_cnt[i] - s_req[i]), 64'(edrawn[i]));
            check($sformatf("%s.u%0d.req_cycles", tag, i), 64'(req_cycles[i] - s_rc[i]),
                  64'(edrawn[i] * (lat + 1)));
            check($sformatf("%s.u%0d.fb_reads", tag, i), 64'(rd_cnt[i] - s_rd[i]), 64'(edrawn[i]));
            check($sformatf("%s.u%0d.fb_writes", tag, i), 64'(wr_cnt[i] - s_wr[i]), 64'(edrawn[i]));
            check($sformatf("%s.u%0d.fb_overlap", tag, i), 64'(overlap[i] - s_ov[i]), 64'd0);
            for (int r = 0; r < edrawn[i]; r++)
                check($sformatf("%s.u%0d.addr%0d", tag, i, r), addr_log[i][(s_req[i] + r) & 255],
                      64'((addr + r) % 4096));
        end
        check_fb(tag);
    endtask

    initial begin
        bit rc [2];
        int rd [2];
        int s_wr [2];
        checks      = 0;
        failures    = 0;
        mem_lat     = 1;
        rst_n       = 1'b0;
        start_in    = 1'b0;
        x_in        = '0;
        y_in        = '0;
        n_in        = '0;
        sprite_addr = '0;
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        for (int r = 0; r < 32; r++) begin
            exp_fb[0][r] = '0;
            exp_fb[1][r] = '0;
        end
        repeat (3) @(negedge clk_in);
        check_outputs_zero("reset");
        #2 rst_n = 1'b1;

        mem[12'h200] = 8'hF0;
        run_draw("t1", 0, 0, 1, 12'h200, 1, 0, 0);
        check("t1.row0_const", fb[0][0], 64'h0000_0000_0000_000F);
        run_draw("t2", 0, 0, 1, 12'h200, 1, 0, 0);
        check("t2.coll_const", coll[0], 1'b1);

        mem[12'h300] = 8'hFF;
        run_draw("t3", 60, 0, 1, 12'h300, 1, 0, 0);
        check("t3.clip_const", fb[0][0], 64'hF000_0000_0000_0000);
        check("t3.wrap_const", fb[1][0], 64'hF000_0000_0000_000F);

        run_draw("t4", 20, 30, 5, 12'h400, 1, 0, 0);
        mem[12'h500] = 8'h80;
        run_draw("t4x", 70, 10, 1, 12'h500, 1, 0, 0);
        check("t4x.col6_const", fb[0][10], 64'h40);

        run_draw("t5n0", 7, 7, 0, 12'h123, 1, 0, 0);
        run_draw("t5wrap", 33, 12, 2, 12'hFFF, 5, 0, 0);

        run_draw("t6start", 8, 3, 3, 12'h600, 1, 5, 13);

        // Async reset in the middle of row 2's fetch.
        mem_lat = 3;
        for (int i = 0; i < 2; i++) s_wr[i] = wr_cnt[i];
        @(negedge clk_in);
        x_in        = 8'd5;
        y_in        = 8'd2;
        n_in        = 4'd4;
        sprite_addr = 12'h700;
        start_in    = 1'b1;
        @(negedge clk_in);
        start_in = 1'b0;
        repeat (13) @(negedge clk_in);
        for (int i = 0; i < 2; i++)
            check($sformatf("t6rst.u%0d.in_fetch", i), mem_req[i], 1'b1);
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("t6rst");
        repeat (3) @(negedge clk_in);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk_in);
        for (int i = 0; i < 2; i++) begin
            ref_draw(i, 5, 2, 4, 12'h700, 2, rc[i], rd[i]);
            check($sformatf("t6rst.u%0d.writes", i), 64'(wr_cnt[i] - s_wr[i]), 64'd2);
            check($sformatf("t6rst.u%0d.busy", i), busy[i], 1'b0);
        end
        check_fb("t6rst");

        for (int t = 0; t < 12; t++)
            run_draw($sformatf("rnd%0d", t), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 15)),
                     int'($urandom_range(0, 4095)), int'($urandom_range(1, 3)), 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
